// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with valid qualification,
// synchronous clear, selectable overlap / Mealy-Moore output and a
// saturating match counter.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   b          in   serial data bit
//   b_valid    in   b is sampled only when high
//   clr        in   synchronous clear of history, fill and match_cnt
//   x          out  one-cycle match pulse
//   match_cnt  out  saturating count of matches since reset/clr
//   fill       out  number of valid history bits held (0..N)
module seq_detect_param #(
    parameter int              N       = 3,
    parameter logic [N-1:0]    PATTERN = N'(3'b101),
    parameter bit              OVERLAP = 1'b0,
    parameter bit              MOORE   = 1'b0,
    parameter int              CNT_W   = 8,
    localparam int             FW      = $clog2(N + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             b,
    input  logic             b_valid,
    input  logic             clr,
    output logic             x,
    output logic [CNT_W-1:0] match_cnt,
    output logic [FW-1:0]    fill
);

    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x;

    logic [N-1:0]     w_next;
    logic             w_full;
    logic             w_hit;

    assign w_next = {r_hist[N-2:0], b};

    // N-1 stored bits plus the incoming one complete a candidate window
    assign w_full = (r_fill >= FW'(N - 1));

    // Rst_n gating keeps the Mealy pulse low throughout reset
    assign w_hit = Rst_n & b_valid & ~clr & w_full
                 & (w_next == PATTERN);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_x    <= 1'b0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_x    <= 1'b0;
        end else begin
            r_x <= w_hit;
            if (b_valid) begin
                r_hist <= w_next;
                if (w_hit) begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // non-overlap: next match needs N fresh bits
                    r_fill <= OVERLAP ? FW'(N) : '0;
                end else if (r_fill != FW'(N)) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    assign x         = MOORE ? r_x : w_hit;
    assign match_cnt = r_cnt;
    assign fill      = r_fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four instances (default, overlap,
// Moore, narrow-counter overlap) driven by shared directed stimulus.
module tb_seq_detect_param;

    localparam int N = 3;
    localparam logic [N-1:0] PAT = 3'b101;

    logic Clk = 1'b0;
    logic Rst_n;
    logic b;
    logic b_valid;
    logic clr;

    logic       x0, x1, x2, x3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [1:0] f0, f1, f2, f3;

    always #5 Clk = ~Clk;

    seq_detect_param u0 (
        .Clk(Clk), .Rst_n(Rst_n), .b(b), .b_valid(b_valid), .clr(clr),
        .x(x0), .match_cnt(c0), .fill(f0)
    );
    seq_detect_param #(.OVERLAP(1'b1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .b(b), .b_valid(b_valid), .clr(clr),
        .x(x1), .match_cnt(c1), .fill(f1)
    );
    seq_detect_param #(.MOORE(1'b1)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .b(b), .b_valid(b_valid), .clr(clr),
        .x(x2), .match_cnt(c2), .fill(f2)
    );
    seq_detect_param #(.OVERLAP(1'b1), .CNT_W(2)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .b(b), .b_valid(b_valid), .clr(clr),
        .x(x3), .match_cnt(c3), .fill(f3)
    );

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: bits received since the last discard (reset, clr or a
    // non-overlapping match); the window is the newest N of them.
    bit ov   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit moore[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cmax [4] = '{255, 255, 255, 3};

    bit mq[4][$];
    int mcnt[4];
    bit mx[4];

    function automatic bit mhit(int i);
        int sz;
        if (!Rst_n || !b_valid || clr) return 1'b0;
        sz = mq[i].size();
        if (sz < N - 1) return 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (mq[i][sz - (N - 1) + k] != PAT[N - 1 - k]) return 1'b0;
        end
        return b == PAT[0];
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        bit h[4];
        for (int i = 0; i < 4; i++) h[i] = mhit(i);
        for (int i = 0; i < 4; i++) begin
            if (!Rst_n || clr) begin
                mq[i].delete();
                mcnt[i] = 0;
                mx[i]   = 1'b0;
            end else begin
                mx[i] = h[i];
                if (b_valid) begin
                    if (h[i] && mcnt[i] < cmax[i]) mcnt[i]++;
                    if (h[i] && !ov[i]) begin
                        mq[i].delete();
                    end else begin
                        mq[i].push_back(b);
                        if (mq[i].size() > N) void'(mq[i].pop_front());
                    end
                end
            end
        end
    end

    function automatic int mfill(int i);
        return (mq[i].size() > N) ? N : mq[i].size();
    endfunction

    // Compare all instances against the model every cycle, after the
    // inputs for the coming edge have settled.
    always @(negedge Clk) begin
        int gx[4];
        int gc[4];
        int gf[4];
        if (chk_en) begin
            #3;
            gx = '{int'(x0), int'(x1), int'(x2), int'(x3)};
            gc = '{int'(c0), int'(c1), int'(c2), int'(c3)};
            gf = '{int'(f0), int'(f1), int'(f2), int'(f3)};
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("x[%0d]", i), gx[i],
                    moore[i] ? int'(mx[i]) : int'(mhit(i)));
                chk($sformatf("cnt[%0d]", i), gc[i], mcnt[i]);
                chk($sformatf("fill[%0d]", i), gf[i], mfill(i));
            end
        end
    end

    task automatic step(input logic bb, input logic vv, input logic cc);
        @(negedge Clk);
        #1;
        b       = bb;
        b_valid = vv;
        clr     = cc;
    endtask

    logic [63:0] vbits = 64'hB5AD_6D5A_A5B6_9D2B;
    logic [63:0] vval  = 64'hFF7F_DFFB_FEFF_BFF7;

    initial begin
        Rst_n   = 1'b1;
        b       = 1'b0;
        b_valid = 1'b0;
        clr     = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        chk("rst_cnt", int'(c0), 0);
        chk("rst_fill", int'(f0), 0);
        chk("rst_x", int'(x2), 0);
        chk_en = 1'b1;
        @(negedge Clk);
        #1 Rst_n = 1'b1;

        // basic 101
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        #1 chk("t2_x", int'(x0), 1);
        @(posedge Clk);
        #1;
        chk("t2_cnt", int'(c0), 1);
        chk("t2_xoff", int'(x0), 0);

        // async reset mid-run while a Mealy hit is pending
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        #1 Rst_n = 1'b0;
        #1;
        chk("t1_x", int'(x0), 0);
        chk("t1_cnt", int'(c0), 0);
        chk("t1_fill", int'(f1), 0);
        @(negedge Clk);
        #1 Rst_n = 1'b1;

        // 10101: overlap vs non-overlap
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(i % 2 == 0, 1, 0);
        step(0, 0, 0);
        #1;
        chk("t3_cnt_nov", int'(c0), 1);
        chk("t3_cnt_ov", int'(c1), 2);

        // valid gaps, Mealy vs Moore timing
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 1, 0);
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        #1;
        chk("t4_mealy", int'(x0), 1);
        chk("t4_moore_early", int'(x2), 0);
        step(0, 0, 0);
        #1;
        chk("t4_moore", int'(x2), 1);
        chk("t4_mealy_off", int'(x0), 0);
        step(0, 0, 0);
        #1 chk("t4_moore_off", int'(x2), 0);

        // five overlapping matches, 2-bit counter saturates
        step(0, 0, 1);
        for (int i = 0; i < 11; i++) step(i % 2 == 0, 1, 0);
        step(0, 0, 0);
        #1;
        chk("t5_sat", int'(c3), 3);
        chk("t5_cnt_ov", int'(c1), 5);

        // clr on the final bit suppresses the match
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 1);
        #1 chk("t6_clr_x", int'(x0), 0);
        step(0, 0, 0);
        #1;
        chk("t6_clr_cnt", int'(c0), 0);
        chk("t6_clr_fill", int'(f0), 0);

        // reset between 10 and 1 loses progress
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        #1 Rst_n = 1'b0;
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        step(1, 1, 0);
        #1 chk("t6_rst_x", int'(x0), 0);

        // longer directed vector with gaps and one clear
        for (int i = 0; i < 64; i++) begin
            step(vbits[i], vval[i], i == 40);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge Clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
